// File: rtl/mini_aie_pkg.sv
// mini-AIE 2x2 CGRA tile: shared constants, opcodes and saturation helper.
// Optional build macro: MINI_AIE_RELU_EN (ReLU applied to READ data).
package mini_aie_pkg;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 16;
  localparam int SUM_W  = 18;

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_WLOAD  = 3'd1;
  localparam logic [2:0] OP_XIN    = 3'd2;
  localparam logic [2:0] OP_RUN    = 3'd3;
  localparam logic [2:0] OP_CLRACC = 3'd4;
  localparam logic [2:0] OP_READ   = 3'd5;

  localparam logic signed [SUM_W-1:0] SAT_MAX = 18'sd32767;
  localparam logic signed [SUM_W-1:0] SAT_MIN = -18'sd32768;

  typedef enum logic {
    ST_IDLE,
    ST_CASCADE
  } state_t;

  typedef struct packed {
    logic             ovf;
    logic [ACC_W-1:0] val;
  } sat_t;

  // Clamp an 18-bit sum into the 16-bit accumulator range.
  function automatic sat_t sat_acc(input logic signed [SUM_W-1:0] s);
    sat_t r;
    if (s > SAT_MAX) begin
      r.val = 16'h7FFF;
      r.ovf = 1'b1;
    end else if (s < SAT_MIN) begin
      r.val = 16'h8000;
      r.ovf = 1'b1;
    end else begin
      r.val = s[ACC_W-1:0];
      r.ovf = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/mini_aie_col.sv
// mini-AIE column: two weights, row-0 product pipeline register and
// saturating accumulator for one output column.
module mini_aie_col
  import mini_aie_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     w0_we_i,
  input  logic                     w1_we_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic signed [DATA_W-1:0] x0_i,
  input  logic signed [DATA_W-1:0] x1_i,
  input  logic                     st1_i,
  input  logic                     st2_i,
  input  logic                     clr_i,
  output logic signed [ACC_W-1:0]  acc_o,
  output logic                     ovf_o
);

  logic signed [DATA_W-1:0] w0_q;
  logic signed [DATA_W-1:0] w1_q;
  logic signed [ACC_W-1:0]  p_q;
  logic signed [ACC_W-1:0]  acc_q;

  logic signed [ACC_W-1:0]  prod0;
  logic signed [ACC_W-1:0]  prod1;
  logic signed [SUM_W-1:0]  sum;
  sat_t                     sat;

  // Row products, stage-2 sum at 18 bits and clamp.
  always_comb begin
    prod0 = $signed({{DATA_W{x0_i[DATA_W-1]}}, x0_i})
          * $signed({{DATA_W{w0_q[DATA_W-1]}}, w0_q});
    prod1 = $signed({{DATA_W{x1_i[DATA_W-1]}}, x1_i})
          * $signed({{DATA_W{w1_q[DATA_W-1]}}, w1_q});
    sum   = $signed({{2{acc_q[ACC_W-1]}}, acc_q})
          + $signed({{2{p_q[ACC_W-1]}}, p_q})
          + $signed({{2{prod1[ACC_W-1]}}, prod1});
    sat   = sat_acc(sum);
  end

  assign acc_o = acc_q;
  assign ovf_o = st2_i & sat.ovf;

  // Weight storage, row-0 pipeline and accumulator update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w0_q  <= '0;
      w1_q  <= '0;
      p_q   <= '0;
      acc_q <= '0;
    end else begin
      if (w0_we_i) w0_q <= wdata_i;
      if (w1_we_i) w1_q <= wdata_i;
      if (st1_i)   p_q  <= prod0;
      if (clr_i)
        acc_q <= '0;
      else if (st2_i)
        acc_q <= sat.val;
    end
  end

endmodule

// File: rtl/mini_aie_2x2_core.sv
// mini-AIE 2x2 core: command decode, RUN cascade FSM, ovf and READ mux.
// Optional build macro: MINI_AIE_RELU_EN (ReLU applied to READ data).
module mini_aie_2x2_core
  import mini_aie_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  state_t                   state_q;
  logic signed [DATA_W-1:0] x0_q;
  logic signed [DATA_W-1:0] x1_q;
  logic                     ovf_q;
  logic [7:0]               rdata_q;

  logic       accept;
  logic [2:0] op;
  logic [1:0] addr;
  logic       is_wload;
  logic       is_xin;
  logic       is_run;
  logic       is_clr;
  logic       is_read;
  logic       cascade;

  logic signed [ACC_W-1:0] acc0;
  logic signed [ACC_W-1:0] acc1;
  logic                    ovf0;
  logic                    ovf1;
  logic [ACC_W-1:0]        rd_val;
  logic [7:0]              rd_byte;

  logic unused_bits;
  assign unused_bits = ^uio_in[1:0];

  assign op      = uio_in[6:4];
  assign addr    = uio_in[3:2];
  assign cascade = (state_q == ST_CASCADE);
  assign accept  = ena & uio_in[7] & ~cascade;

  // Opcode decode, gated by command acceptance.
  always_comb begin
    is_wload = 1'b0;
    is_xin   = 1'b0;
    is_run   = 1'b0;
    is_clr   = 1'b0;
    is_read  = 1'b0;
    if (accept) begin
      case (op)
        OP_WLOAD:  is_wload = 1'b1;
        OP_XIN:    is_xin   = 1'b1;
        OP_RUN:    is_run   = 1'b1;
        OP_CLRACC: is_clr   = 1'b1;
        OP_READ:   is_read  = 1'b1;
        default:   ;
      endcase
    end
  end

  mini_aie_col u_col0 (
    .clk     (clk),
    .rst     (rst),
    .w0_we_i (is_wload & ~addr[1] & ~addr[0]),
    .w1_we_i (is_wload &  addr[1] & ~addr[0]),
    .wdata_i (ui_in),
    .x0_i    (x0_q),
    .x1_i    (x1_q),
    .st1_i   (is_run),
    .st2_i   (cascade),
    .clr_i   (is_clr),
    .acc_o   (acc0),
    .ovf_o   (ovf0)
  );

  mini_aie_col u_col1 (
    .clk     (clk),
    .rst     (rst),
    .w0_we_i (is_wload & ~addr[1] & addr[0]),
    .w1_we_i (is_wload &  addr[1] & addr[0]),
    .wdata_i (ui_in),
    .x0_i    (x0_q),
    .x1_i    (x1_q),
    .st1_i   (is_run),
    .st2_i   (cascade),
    .clr_i   (is_clr),
    .acc_o   (acc1),
    .ovf_o   (ovf1)
  );

  // READ source: selected accumulator, optionally rectified.
  always_comb begin
    rd_val = addr[1] ? acc1 : acc0;
`ifdef MINI_AIE_RELU_EN
    if (rd_val[ACC_W-1]) rd_val = '0;
`endif
    rd_byte = addr[0] ? rd_val[15:8] : rd_val[7:0];
  end

  // RUN cascade FSM with sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (is_run) state_q <= ST_CASCADE;
          if (is_clr) ovf_q <= 1'b0;
        end
        ST_CASCADE: begin
          state_q <= ST_IDLE;
          ovf_q   <= ovf_q | ovf0 | ovf1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Activation registers and READ data register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x0_q    <= '0;
      x1_q    <= '0;
      rdata_q <= '0;
    end else begin
      if (is_xin & ~addr[0]) x0_q <= ui_in;
      if (is_xin &  addr[0]) x1_q <= ui_in;
      if (is_read) rdata_q <= rd_byte;
    end
  end

  assign uo_out  = rdata_q;
  assign uio_out = {6'b0, ovf_q, cascade};
  assign uio_oe  = 8'h03;

endmodule

// File: tb/tb_mini_aie_2x2_core.sv
// Directed bench for mini_aie_2x2_core: vector table plus
// hand-written sequences for busy window, reset and ena corners.
module tb_mini_aie_2x2_core;

  logic       clk;
  logic       rst;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_vec;
  int n_err;

  localparam logic [2:0] NOP = 3'd0;
  localparam logic [2:0] WLD = 3'd1;
  localparam logic [2:0] XIN = 3'd2;
  localparam logic [2:0] RUN = 3'd3;
  localparam logic [2:0] CLR = 3'd4;
  localparam logic [2:0] RD  = 3'd5;

`ifdef MINI_AIE_RELU_EN
  localparam logic [7:0] R_LO = 8'h00;
  localparam logic [7:0] R_HI = 8'h00;
`else
  localparam logic [7:0] R_LO = 8'hFB;
  localparam logic [7:0] R_HI = 8'hFF;
`endif

  typedef struct {
    logic [2:0] op;
    logic [1:0] addr;
    logic [7:0] data;
    logic [7:0] exp_uo;
    logic [7:0] exp_uio;
  } vec_t;

  vec_t tbl[$];

  mini_aie_2x2_core dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic void add(input logic [2:0] op, input logic [1:0] a,
                              input logic [7:0] d, input logic [7:0] uo,
                              input logic [7:0] uio);
    vec_t v;
    v.op = op; v.addr = a; v.data = d; v.exp_uo = uo; v.exp_uio = uio;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [7:0] got,
                     input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", nm, got, exp);
    end
  endtask

  // Issue one command at a negedge, idle one cycle, end on a negedge.
  task automatic step(input logic [2:0] op, input logic [1:0] a,
                      input logic [7:0] d);
    ui_in  = d;
    uio_in = {1'b1, op, a, 2'b00};
    @(negedge clk);
    uio_in = 8'h00;
    @(negedge clk);
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    rst    = 1'b1;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;

    // Reset readback, then read of all four bytes.
    add(RD, 2'd0, 8'h00, 8'h00, 8'h00);
    add(RD, 2'd1, 8'h00, 8'h00, 8'h00);
    add(RD, 2'd2, 8'h00, 8'h00, 8'h00);
    add(RD, 2'd3, 8'h00, 8'h00, 8'h00);
    // Matrix-vector run.
    add(WLD, 2'd0, 8'h02, 8'h00, 8'h00);
    add(WLD, 2'd1, 8'h03, 8'h00, 8'h00);
    add(WLD, 2'd2, 8'h04, 8'h00, 8'h00);
    add(WLD, 2'd3, 8'hFF, 8'h00, 8'h00);
    add(XIN, 2'd0, 8'h05, 8'h00, 8'h00);
    add(XIN, 2'd1, 8'h06, 8'h00, 8'h00);
    add(RUN, 2'd0, 8'h00, 8'h00, 8'h00);
    add(RD,  2'd0, 8'h00, 8'h22, 8'h00);
    add(RD,  2'd1, 8'h00, 8'h00, 8'h00);
    add(RD,  2'd2, 8'h00, 8'h09, 8'h00);
    add(RD,  2'd3, 8'h00, 8'h00, 8'h00);
    // Saturation.
    add(CLR, 2'd0, 8'h00, 8'h00, 8'h00);
    add(WLD, 2'd0, 8'h7F, 8'h00, 8'h00);
    add(WLD, 2'd1, 8'h7F, 8'h00, 8'h00);
    add(WLD, 2'd2, 8'h7F, 8'h00, 8'h00);
    add(WLD, 2'd3, 8'h7F, 8'h00, 8'h00);
    add(XIN, 2'd0, 8'h7F, 8'h00, 8'h00);
    add(XIN, 2'd1, 8'h7F, 8'h00, 8'h00);
    add(RUN, 2'd0, 8'h00, 8'h00, 8'h00);
    add(RD,  2'd0, 8'h00, 8'h02, 8'h00);
    add(RD,  2'd1, 8'h00, 8'h7E, 8'h00);
    add(RUN, 2'd0, 8'h00, 8'h7E, 8'h02);
    add(RD,  2'd0, 8'h00, 8'hFF, 8'h02);
    add(RD,  2'd3, 8'h00, 8'h7F, 8'h02);
    add(NOP, 2'd0, 8'h00, 8'h7F, 8'h02);
    add(CLR, 2'd0, 8'h00, 8'h7F, 8'h00);
    add(RD,  2'd1, 8'h00, 8'h00, 8'h00);
    add(RD,  2'd2, 8'h00, 8'h00, 8'h00);
    // ReLU on a negative column, positive column untouched.
    add(WLD, 2'd1, 8'hFF, 8'h00, 8'h00);
    add(XIN, 2'd0, 8'h05, 8'h00, 8'h00);
    add(XIN, 2'd1, 8'h00, 8'h00, 8'h00);
    add(RUN, 2'd0, 8'h00, 8'h00, 8'h00);
    add(RD,  2'd2, 8'h00, R_LO,  8'h00);
    add(RD,  2'd3, 8'h00, R_HI,  8'h00);
    add(RD,  2'd0, 8'h00, 8'h7B, 8'h00);
    add(RD,  2'd1, 8'h00, 8'h02, 8'h00);

    @(negedge clk);
    chk("reset uo_out", uo_out, 8'h00);
    chk("reset uio_out", uio_out, 8'h00);
    chk("reset uio_oe", uio_oe, 8'h03);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].op, tbl[i].addr, tbl[i].data);
      chk($sformatf("vec%0d uo_out", i), uo_out, tbl[i].exp_uo);
      chk($sformatf("vec%0d uio_out", i), uio_out, tbl[i].exp_uio);
    end

    // Busy window: READ right after RUN is dropped. acc0 -> 1270.
    ui_in  = 8'h00;
    uio_in = {1'b1, RUN, 2'd0, 2'b00};
    @(negedge clk);
    chk("busy after RUN", uio_out, 8'h01);
    uio_in = {1'b1, RD, 2'd0, 2'b00};
    @(negedge clk);
    chk("busy drops E+1", uio_out, 8'h00);
    chk("READ dropped", uo_out, 8'h02);
    @(negedge clk);
    uio_in = 8'h00;
    chk("READ at E+2", uo_out, 8'hF6);
    chk("no busy E+2", uio_out, 8'h00);

    // Reset during CASCADE aborts the run.
    uio_in = {1'b1, RUN, 2'd0, 2'b00};
    @(negedge clk);
    uio_in = 8'h00;
    chk("busy before rst", uio_out, 8'h01);
    rst = 1'b1;
    #1;
    chk("async rst busy", uio_out, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    step(RD, 2'd0, 8'h00);
    chk("rst acc0 lo", uo_out, 8'h00);
    step(RD, 2'd1, 8'h00);
    chk("rst acc0 hi", uo_out, 8'h00);
    step(RD, 2'd2, 8'h00);
    chk("rst acc1 lo", uo_out, 8'h00);

    // ena=0 blocks XIN; acc0 stays 0 with w00=3.
    step(WLD, 2'd0, 8'h03);
    ena = 1'b0;
    step(XIN, 2'd0, 8'h04);
    ena = 1'b1;
    step(RUN, 2'd0, 8'h00);
    step(RD, 2'd0, 8'h00);
    chk("ena0 XIN blocked", uo_out, 8'h00);

    // ena=0 blocks WLOAD, and does not stall the cascade.
    step(XIN, 2'd0, 8'h04);
    ena = 1'b0;
    step(WLD, 2'd0, 8'h7F);
    ena = 1'b1;
    uio_in = {1'b1, RUN, 2'd0, 2'b00};
    @(negedge clk);
    ena    = 1'b0;
    uio_in = 8'h00;
    chk("busy ena0", uio_out, 8'h01);
    @(negedge clk);
    chk("cascade done ena0", uio_out, 8'h00);
    ena = 1'b1;
    step(RD, 2'd0, 8'h00);
    chk("ena0 WLOAD blocked", uo_out, 8'h0C);
    step(RD, 2'd1, 8'h00);
    chk("ena0 acc0 hi", uo_out, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
